// File: rtl/pkt_guard.sv
// Store-and-forward guard in front of the packet sorter.
// Forwards only well-formed packets; counts forwarded and discarded ones.
module pkt_guard #(
    parameter int DWIDTH      = 16,
    parameter int MAX_PKT_LEN = 13,
    parameter int CWIDTH      = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic [CWIDTH-1:0] pkt_cnt_o,
    output logic [CWIDTH-1:0] drop_cnt_o
);

    localparam int PW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
    localparam logic [PW-1:0] MAXP = PW'(MAX_PKT_LEN);

    typedef enum logic [1:0] {IDLE, FILL, DROP, SEND} state_t;

    state_t            state;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     len;
    logic [PW-1:0]     rd_nxt;
    logic [DWIDTH-1:0] mem [MAX_PKT_LEN];

    logic              in_beat;
    logic              out_beat;
    logic              wr_en;
    logic [PW-1:0]     wr_idx;

    assign in_beat  = snk_valid_i && snk_ready_o && (state != SEND);
    assign out_beat = src_valid_o && src_ready_i;
    assign rd_nxt   = rd_ptr + PW'(1);

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] c);
        return (c == '1) ? c : c + CWIDTH'(1);
    endfunction

    // Select which buffer slot (if any) the current input beat lands in.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (in_beat) begin
            if (snk_startofpacket_i) begin
                wr_en = 1'b1;
            end else if (state == FILL && wr_ptr < MAXP) begin
                wr_en  = 1'b1;
                wr_idx = wr_ptr;
            end
        end
    end

    // Packet buffer; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[AW'(wr_idx)] <= snk_data_i;
    end

    // Control FSM with registered handshake, framing and counters.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state               <= IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            len                 <= '0;
            snk_ready_o         <= 1'b0;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            src_data_o          <= '0;
            pkt_cnt_o           <= '0;
            drop_cnt_o          <= '0;
        end else begin
            if (state != SEND) snk_ready_o <= 1'b1;
            unique case (state)
                IDLE, DROP: begin
                    if (in_beat && !snk_startofpacket_i) begin
                        if (state == IDLE) begin
                            drop_cnt_o <= sat_inc(drop_cnt_o);
                        end else if (snk_endofpacket_i) begin
                            state <= IDLE;
                        end
                    end
                end
                FILL: begin
                    if (in_beat) begin
                        if (snk_startofpacket_i) begin
                            drop_cnt_o <= sat_inc(drop_cnt_o);
                        end else if (wr_ptr < MAXP) begin
                            if (snk_endofpacket_i) begin
                                // Word 0 is already buffered here
                                len                 <= wr_ptr + PW'(1);
                                wr_ptr              <= '0;
                                rd_ptr              <= '0;
                                state               <= SEND;
                                snk_ready_o         <= 1'b0;
                                src_valid_o         <= 1'b1;
                                src_startofpacket_o <= 1'b1;
                                src_endofpacket_o   <= 1'b0;
                                src_data_o          <= mem[0];
                            end else begin
                                wr_ptr <= wr_ptr + PW'(1);
                            end
                        end else begin
                            drop_cnt_o <= sat_inc(drop_cnt_o);
                            wr_ptr     <= '0;
                            state      <= snk_endofpacket_i ? IDLE : DROP;
                        end
                    end
                end
                SEND: begin
                    if (out_beat) begin
                        if (src_endofpacket_o) begin
                            pkt_cnt_o           <= sat_inc(pkt_cnt_o);
                            state               <= IDLE;
                            snk_ready_o         <= 1'b1;
                            src_valid_o         <= 1'b0;
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= 1'b0;
                            src_data_o          <= '0;
                            rd_ptr              <= '0;
                        end else begin
                            rd_ptr              <= rd_nxt;
                            src_data_o          <= mem[AW'(rd_nxt)];
                            src_startofpacket_o <= 1'b0;
                            src_endofpacket_o   <= (rd_nxt == len - PW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            // A sop beat always opens a fresh packet in slot 0
            if (in_beat && snk_startofpacket_i) begin
                if (snk_endofpacket_i) begin
                    len                 <= PW'(1);
                    wr_ptr              <= '0;
                    rd_ptr              <= '0;
                    state               <= SEND;
                    snk_ready_o         <= 1'b0;
                    src_valid_o         <= 1'b1;
                    src_startofpacket_o <= 1'b1;
                    src_endofpacket_o   <= 1'b1;
                    src_data_o          <= snk_data_i;
                end else begin
                    wr_ptr <= PW'(1);
                    state  <= FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_guard.sv
// Directed bench for pkt_guard with an output scoreboard.
// Counters are narrowed to 4 bits so saturation is reachable.
module tb_pkt_guard;

    localparam int DW = 16;
    localparam int ML = 13;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [DW-1:0] snk_data;
    logic          snk_sop, snk_eop, snk_valid, snk_ready;
    logic [DW-1:0] src_data;
    logic          src_sop, src_eop, src_valid, src_ready;
    logic [CW-1:0] pkt_cnt, drop_cnt;

    always #5 clk = ~clk;

    pkt_guard #(.DWIDTH(DW), .MAX_PKT_LEN(ML), .CWIDTH(CW)) dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid),
        .snk_ready_o         (snk_ready),
        .src_data_o          (src_data),
        .src_startofpacket_o (src_sop),
        .src_endofpacket_o   (src_eop),
        .src_valid_o         (src_valid),
        .src_ready_i         (src_ready),
        .pkt_cnt_o           (pkt_cnt),
        .drop_cnt_o          (drop_cnt)
    );

    int            tests = 0;
    int            fails = 0;
    int            exp_pkt = 0;
    int            exp_drop = 0;
    logic [17:0]   sb [$];
    logic [DW-1:0] pw [$];
    logic          hold_v = 1'b0;
    logic [17:0]   hold_w = '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_pkt"}, 32'(pkt_cnt), exp_pkt);
        check({tag, "_drop"}, 32'(drop_cnt), exp_drop);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic s,
                             input logic e);
        int n;
        n = 0;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
        snk_valid = 1'b1;
        while (n < 200) begin
            @(negedge clk);
            if (snk_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            n++;
        end
        check("beat_accept", 32'(n < 200), 1);
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic send_words(input bit s_first, input bit e_last,
                              input bit fwd);
        int last;
        last = pw.size() - 1;
        if (fwd) begin
            for (int i = 0; i <= last; i++)
                sb.push_back({1'(i == 0), 1'(i == last), pw[i]});
        end
        for (int i = 0; i <= last; i++)
            send_beat(pw[i], s_first && i == 0, e_last && i == last);
        pw.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || src_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(n < 200), 1);
    endtask

    // Output monitor: scoreboard pops, hold stability, no input ready in SEND.
    always @(negedge clk) begin
        logic [17:0] e;
        if (!arst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(src_valid), 1);
                check("hold_word", 32'({src_sop, src_eop, src_data}), 32'(hold_w));
            end
            if (src_valid) check("rdy_in_send", 32'(snk_ready), 0);
            if (src_valid && src_ready) begin
                check("sb_nonempty", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_word", 32'({src_sop, src_eop, src_data}), 32'(e));
                end
            end
            hold_v = src_valid && !src_ready;
            hold_w = {src_sop, src_eop, src_data};
        end
    end

    initial begin
        int n;
        arst_n    = 1'b0;
        snk_data  = '0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        snk_valid = 1'b0;
        src_ready = 1'b1;
        #23;
        check("rst_ready", 32'(snk_ready), 0);
        check("rst_valid", 32'(src_valid), 0);
        check("rst_out", 32'({src_sop, src_eop, src_data}), 0);
        check_cnt("rst");
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("rel_ready_pre", 32'(snk_ready), 0);
        @(posedge clk);
        #1;
        check("rel_ready_post", 32'(snk_ready), 1);

        // 5-word packet, back-to-back output
        pw = '{16'd1, 16'd5, 16'd3, 16'd9, 16'd2};
        send_words(1, 1, 1);
        check("lat_ready", 32'(snk_ready), 0);
        check("lat_valid", 32'(src_valid), 1);
        check("lat_word", 32'({src_sop, src_data}), 32'({1'b1, 16'd1}));
        n = 0;
        while (src_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("burst_cycles", n, 5);
        check("ready_after", 32'(snk_ready), 1);
        exp_pkt = 1;
        check_cnt("p5");

        // 14-word overflow ending in eop, then 7,8,9
        for (int i = 0; i < 14; i++) pw.push_back(16'(100 + i));
        send_words(1, 1, 0);
        exp_drop = 1;
        pw = '{16'd7, 16'd8, 16'd9};
        send_words(1, 1, 1);
        drain("drain_ovf");
        exp_pkt = 2;
        check_cnt("ovf");

        // Stray beats, then single-word packet
        send_beat(16'd4, 0, 0);
        send_beat(16'd4, 0, 0);
        pw = '{16'd6};
        send_words(1, 1, 1);
        drain("drain_single");
        exp_drop = 3;
        exp_pkt  = 3;
        check_cnt("stray");

        // Back-pressure 1,0,0,...
        pw = '{16'd21, 16'd22, 16'd23, 16'd24};
        send_words(1, 1, 1);
        n = 0;
        while ((sb.size() != 0 || src_valid) && n < 200) begin
            src_ready = (n % 3 == 0);
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_bp", 32'(n < 200), 1);
        src_ready = 1'b1;
        exp_pkt = 4;
        check_cnt("bp");

        // sop inside an open packet restarts it
        pw = '{16'd31, 16'd32};
        send_words(1, 0, 0);
        pw = '{16'd41, 16'd42, 16'd43, 16'd44};
        send_words(1, 1, 1);
        drain("drain_restart");
        exp_drop = 4;
        exp_pkt  = 5;
        check_cnt("restart");

        // Overflow without eop enters DROP; a sop+... packet exits it
        for (int i = 0; i < 14; i++) pw.push_back(16'(200 + i));
        send_words(1, 0, 0);
        exp_drop = 5;
        check_cnt("drop_enter");
        send_beat(16'd99, 0, 0);
        pw = '{16'd71, 16'd72};
        send_words(1, 1, 1);
        drain("drain_drop");
        exp_pkt = 6;
        check_cnt("drop_exit");

        // Drop counter saturates
        for (int i = 0; i < 14; i++) begin
            send_beat(16'd0, 0, 0);
            exp_drop = (exp_drop < 15) ? exp_drop + 1 : 15;
        end
        check_cnt("sat");

        // Reset while word 2 of a packet is being presented
        src_ready = 1'b0;
        pw = '{16'd51, 16'd52, 16'd53};
        send_words(1, 1, 1);
        src_ready = 1'b1;
        @(posedge clk);
        #1;
        src_ready = 1'b0;
        check("mid_word2", 32'(src_data), 52);
        #2;
        arst_n = 1'b0;
        #1;
        sb.delete();
        exp_pkt  = 0;
        exp_drop = 0;
        check("mid_rst_ready", 32'(snk_ready), 0);
        check("mid_rst_valid", 32'(src_valid), 0);
        check("mid_rst_out", 32'({src_sop, src_eop, src_data}), 0);
        check_cnt("mid_rst");
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        check("mid_rel_pre", 32'(snk_ready), 0);
        @(posedge clk);
        #1;
        check("mid_rel_post", 32'(snk_ready), 1);
        src_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_partial", 32'(src_valid), 0);
        pw = '{16'd61, 16'd62};
        send_words(1, 1, 1);
        drain("drain_post");
        exp_pkt = 1;
        check_cnt("post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_guard.md
PKT_GUARD -- requirements
Module: pkt_guard

Interface
REQ-001 Parameter: DWIDTH, 16, data word width.
REQ-002 Parameter: MAX_PKT_LEN, 13, maximum accepted packet length in words (>=1); must equal the downstream sorter's MAX_PKT_LEN.
REQ-003 Parameter: CWIDTH, 16, width of statistics counters.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 arst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 snk_data_i  in  DWIDTH  input Avalon-ST data.
REQ-007 snk_startofpacket_i / snk_endofpacket_i / snk_valid_i  in  1 each  input framing and valid.
REQ-008 snk_ready_o  out  1  input ready.
REQ-009 src_data_o  out  DWIDTH  output data to sorter.
REQ-010 src_startofpacket_o / src_endofpacket_o / src_valid_o  out  1 each  output framing and valid.
REQ-011 src_ready_i  in  1  output ready from sorter.
REQ-012 pkt_cnt_o  out  CWIDTH  packets forwarded; drop_cnt_o  out  CWIDTH  packets/stray beats discarded.

Function
REQ-013 Input beat = snk_valid_i && snk_ready_o; output beat = src_valid_o && src_ready_i.
REQ-014 Store-and-forward: a packet is emitted only after its eop beat is accepted and only if well-formed (sop first, eop within MAX_PKT_LEN words).
REQ-015 Buffer: MAX_PKT_LEN x DWIDTH registers, write pointer wr_ptr and length len, width $clog2(MAX_PKT_LEN+1).
REQ-016 States: IDLE, FILL, DROP, SEND; snk_ready_o registered, 1 in IDLE/FILL/DROP, 0 in SEND.
REQ-017 IDLE: beat with sop and eop -> buf[0] written, len=1, -> SEND; beat with sop only -> buf[0] written, wr_ptr=1, -> FILL; beat without sop -> discarded, drop_cnt_o+1, stay IDLE.
REQ-018 FILL: beat with sop -> current packet abandoned, drop_cnt_o+1, beat stored as new buf[0], wr_ptr=1 (-> SEND if it also carries eop, len=1).
REQ-019 FILL: beat without sop, wr_ptr<MAX_PKT_LEN -> buf[wr_ptr] written; if eop, len=wr_ptr+1 -> SEND, else wr_ptr+1.
REQ-020 FILL: beat without sop arriving with wr_ptr==MAX_PKT_LEN -> overflow: drop_cnt_o+1; -> IDLE if eop, else -> DROP.
REQ-021 DROP: all beats discarded; eop beat -> IDLE; sop beat in DROP -> treated as IDLE sop (REQ-017, eop included), no extra drop count.
REQ-022 SEND: src_valid_o=1 from first cycle in SEND; src_data_o=buf[rd_ptr], rd_ptr starts 0; src_startofpacket_o=(rd_ptr==0); src_endofpacket_o=(rd_ptr==len-1); single-word packet has both.
REQ-023 SEND: rd_ptr advances only on output beat; outputs hold stable while src_ready_i=0.
REQ-024 SEND: output beat with eop -> pkt_cnt_o+1, src_valid_o=0, -> IDLE, snk_ready_o=1 next cycle.
REQ-025 Latency: eop input beat at edge N -> sop output valid after edge N; snk_ready_o=0 after edge N.
REQ-026 Counters saturate at 2^CWIDTH-1, never wrap.
REQ-027 src_valid_o never asserted outside SEND; no snk_* input inspected in SEND.

Reset
REQ-028 arst_n_i=0 asynchronously forces: state=IDLE, wr_ptr=rd_ptr=len=0, snk_ready_o=0, src_valid_o=0, src_startofpacket_o=0, src_endofpacket_o=0, src_data_o=0, pkt_cnt_o=0, drop_cnt_o=0.
REQ-029 snk_ready_o rises at first rising clk_i edge after arst_n_i deasserts; buffer contents need no reset.
REQ-030 Reset mid-FILL or mid-SEND discards the packet without counting it; no partial packet emitted after release.

Verification
REQ-031 5-word packet 1,5,3,9,2 (sop on 1, eop on 2), src_ready_i=1 -> outputs 1,5,3,9,2 in 5 consecutive cycles, sop on first, eop on last, pkt_cnt_o=1.
REQ-032 14-word packet with MAX_PKT_LEN=13 then 3-word packet 7,8,9 -> nothing emitted for first, drop_cnt_o=1; second emitted 7,8,9, pkt_cnt_o=1.
REQ-033 Stray beats 4,4 without sop, then single-word packet 6 (sop+eop) -> drop_cnt_o=2; output one beat 6 with sop=eop=1.
REQ-034 4-word packet with src_ready_i toggling 1,0,0,1,... -> each word held stable while ready=0, order preserved, snk_ready_o=0 until eop beat accepted.
REQ-035 sop at word 3 of an open packet, then new packet ends at word 4 -> drop_cnt_o=1, only the 4-word new packet emitted.
REQ-036 arst_n_i pulsed low during SEND word 2 -> all outputs 0 immediately, snk_ready_o=1 one edge after release, counters 0.
